// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit cpu.
// Widths, reset vector, opcodes, fetch entry.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BR  = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [3:0] opOf(
    input logic [INST_W-1:0] i
  );
    return i[INST_W-1:INST_W-4];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer between imem responses
// and decode; flush empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wrPtr;
  logic         rdPtr;

  assign dout = mem[rdPtr];

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wrPtr] <= din;
        wrPtr      <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem reads,
// buffers responses and hands them to decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [3:0]        HALT_OPCODE = OP_HLT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus2,
  output logic [ADDR_W-1:0] pc,
  output logic              hlt
);

  logic              inflight;
  logic [ADDR_W-1:0] reqPc;
  logic              fetchStopped;
  logic              squash;
  logic              push;
  logic              pop;
  logic [2:0]        occ;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      din;

  // Once halted, redirects are ignored.
  assign squash = redirect_valid && !hlt;
  assign pop    = id_valid && id_ready;
  assign push   = inflight && !squash;
  assign din    = '{instr: imem_rdata, pc: reqPc};

  // A head popping this cycle frees its slot for the next response.
  assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign imem_en = rst_n && !hlt && !fetchStopped
                && !redirect_valid && (occ < 3'd2);
  assign imem_addr = pc;

  assign id_valid    = (count != 2'd0) && !hlt;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_pc_plus2 = head.pc + ADDR_W'(2);

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (squash),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  // PC, in-flight tracking, speculative stop and committed halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      reqPc        <= '0;
      fetchStopped <= 1'b0;
      hlt          <= 1'b0;
    end else begin
      if (squash) begin
        pc           <= {redirect_pc[ADDR_W-1:1], 1'b0};
        inflight     <= 1'b0;
        fetchStopped <= 1'b0;
      end else begin
        if (imem_en) begin
          pc    <= pc + ADDR_W'(2);
          reqPc <= pc;
        end
        inflight <= imem_en;
        if (push && opOf(imem_rdata) == HALT_OPCODE)
          fetchStopped <= 1'b1;
      end
      if (pop && opOf(head.instr) == HALT_OPCODE)
        hlt <= 1'b1;
    end
  end

endmodule
